// File: rtl/ahb_dma_master.sv
// AHB-Lite single-transfer DMA initiator: copies a block of 32-bit words, one read then one write per word.
// Optional build macro AHB_DMA_DST_FIXED_EN adds I_dst_fixed to keep the destination address constant.
module ahb_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             I_ahb_clk,
  input  logic             I_rst_n,
  input  logic             I_start,
  input  logic [31:0]      I_src_addr,
  input  logic [31:0]      I_dst_addr,
  input  logic [LEN_W-1:0] I_len,
`ifdef AHB_DMA_DST_FIXED_EN
  input  logic             I_dst_fixed,
`endif
  output logic             O_busy,
  output logic             O_done,
  output logic             O_err,
  output logic [1:0]       O_ahb_htrans,
  output logic             O_ahb_hwrite,
  output logic [31:0]      O_ahb_haddr,
  output logic [2:0]       O_ahb_hsize,
  output logic [2:0]       O_ahb_hburst,
  output logic [3:0]       O_ahb_hprot,
  output logic             O_ahb_hmastlock,
  output logic [31:0]      O_ahb_hwdata,
  input  logic [31:0]      I_ahb_hrdata,
  input  logic [1:0]       I_ahb_hresp,
  input  logic             I_ahb_hready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;
  localparam logic [LEN_W-1:0] LEN_ONE       = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO      = '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [29:0]      r_src;
  logic [29:0]      r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_buf;
  logic             r_err;
  logic             w_resp_err;
  logic             w_last;
  logic             w_dst_fixed;
  logic             w_unused_bits;

  assign w_resp_err    = (I_ahb_hresp != 2'b00);
  assign w_last        = (r_cnt == LEN_ONE);
  assign w_unused_bits = ^{I_src_addr[1:0], I_dst_addr[1:0]};

`ifdef AHB_DMA_DST_FIXED_EN
  logic r_fixed;
  always_ff @(posedge I_ahb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_fixed <= 1'b0;
    end else if (r_state == S_IDLE && I_start) begin
      r_fixed <= I_dst_fixed;
    end
  end
  assign w_dst_fixed = r_fixed;
`else
  assign w_dst_fixed = 1'b0;
`endif

  always_ff @(posedge I_ahb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (I_start) begin
          w_state_nxt = (I_len != LEN_ZERO) ? S_RD_ADDR : S_FIN;
        end
      end
      S_RD_ADDR: begin
        if (I_ahb_hready) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (w_resp_err)        w_state_nxt = S_FIN;
        else if (I_ahb_hready) w_state_nxt = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        if (I_ahb_hready) w_state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (w_resp_err)        w_state_nxt = S_FIN;
        else if (I_ahb_hready) w_state_nxt = w_last ? S_FIN : S_RD_ADDR;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Block registers only change at start acceptance or at the end of a data phase.
  always_ff @(posedge I_ahb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_cnt <= '0;
      r_buf <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (I_start) begin
            r_src <= I_src_addr[31:2];
            r_dst <= I_dst_addr[31:2];
            r_cnt <= I_len;
            r_err <= 1'b0;
          end
        end
        S_RD_DATA: begin
          if (w_resp_err)        r_err <= 1'b1;
          else if (I_ahb_hready) r_buf <= I_ahb_hrdata;
        end
        S_WR_DATA: begin
          if (w_resp_err) begin
            r_err <= 1'b1;
          end else if (I_ahb_hready) begin
            r_cnt <= r_cnt - LEN_ONE;
            r_src <= r_src + 30'd1;
            if (!w_dst_fixed) r_dst <= r_dst + 30'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus outputs decode straight from state so an async reset clears them in the same cycle.
  always_comb begin
    O_ahb_htrans = HTRANS_IDLE;
    O_ahb_hwrite = 1'b0;
    O_ahb_haddr  = 32'h0;
    O_ahb_hwdata = 32'h0;
    case (r_state)
      S_RD_ADDR: begin
        O_ahb_htrans = HTRANS_NONSEQ;
        O_ahb_haddr  = {r_src, 2'b00};
      end
      S_WR_ADDR: begin
        O_ahb_htrans = HTRANS_NONSEQ;
        O_ahb_hwrite = 1'b1;
        O_ahb_haddr  = {r_dst, 2'b00};
      end
      S_WR_DATA: O_ahb_hwdata = r_buf;
      default: begin
      end
    endcase
  end

  assign O_busy          = (r_state != S_IDLE);
  assign O_done          = (r_state == S_FIN);
  assign O_err           = r_err;
  assign O_ahb_hsize     = 3'b010;
  assign O_ahb_hburst    = 3'b000;
  assign O_ahb_hprot     = 4'b0011;
  assign O_ahb_hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_dma_master.sv
// Directed bench for ahb_dma_master with a small AHB-Lite slave model (wait states, stalls, error injection).
module tb_ahb_dma_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        dst_fixed;
  logic        busy, done, err;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [1:0]  hresp;
  logic        hready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_dma_master #(.LEN_W(16)) dut (
    .I_ahb_clk      (clk),
    .I_rst_n        (rst_n),
    .I_start        (start),
    .I_src_addr     (src),
    .I_dst_addr     (dst),
    .I_len          (len),
`ifdef AHB_DMA_DST_FIXED_EN
    .I_dst_fixed    (dst_fixed),
`endif
    .O_busy         (busy),
    .O_done         (done),
    .O_err          (err),
    .O_ahb_htrans   (htrans),
    .O_ahb_hwrite   (hwrite),
    .O_ahb_haddr    (haddr),
    .O_ahb_hsize    (hsize),
    .O_ahb_hburst   (hburst),
    .O_ahb_hprot    (hprot),
    .O_ahb_hmastlock(hmastlock),
    .O_ahb_hwdata   (hwdata),
    .I_ahb_hrdata   (hrdata),
    .I_ahb_hresp    (hresp),
    .I_ahb_hready   (hready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: read data is addr ^ 5A5A0F0F, garbage while waiting.
  logic        s_clr;
  int          cfg_dwait, cfg_stall_rd, cfg_err_rd;
  logic        s_dp_act, s_dp_wr, s_dp_err, s_stalled, s_ap_stall;
  logic [31:0] s_dp_addr;
  int          s_dp_wait, s_nr, s_nw;
  logic [31:0] rlog [8];
  logic [31:0] wlog_a [8];
  logic [31:0] wlog_d [8];

  always_comb begin
    s_ap_stall = !s_dp_act && (htrans == 2'b10) && !hwrite &&
                 ((s_nr + 1) == cfg_stall_rd) && !s_stalled;
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = 32'h0;
    if (s_dp_act) begin
      hready = (s_dp_wait == 0) && !s_dp_err;
      if (s_dp_err) hresp = 2'b01;
      if (!s_dp_wr) hrdata = hready ? (s_dp_addr ^ 32'h5A5A_0F0F) : 32'hDEAD_BEEF;
    end else if (s_ap_stall) begin
      hready = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_dp_act <= 1'b0;
    end else if (s_clr) begin
      s_dp_act  <= 1'b0;
      s_dp_err  <= 1'b0;
      s_stalled <= 1'b0;
      s_nr      <= 0;
      s_nw      <= 0;
    end else if (s_dp_act) begin
      if (hready || hresp != 2'b00) begin
        s_dp_act <= 1'b0;
        if (s_dp_wr && hready) begin
          if (s_nw < 8) begin
            wlog_a[s_nw] <= s_dp_addr;
            wlog_d[s_nw] <= hwdata;
          end
          s_nw <= s_nw + 1;
        end
      end else if (s_dp_wait > 0) begin
        s_dp_wait <= s_dp_wait - 1;
      end
    end else if (htrans == 2'b10) begin
      if (s_ap_stall) begin
        s_stalled <= 1'b1;
      end else begin
        s_dp_act  <= 1'b1;
        s_dp_wr   <= hwrite;
        s_dp_addr <= haddr;
        s_dp_wait <= cfg_dwait;
        s_dp_err  <= !hwrite && ((s_nr + 1) == cfg_err_rd);
        if (!hwrite) begin
          if (s_nr < 8) rlog[s_nr] <= haddr;
          s_nr <= s_nr + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, scrambles inputs after acceptance, returns cycles until done (-1 on timeout).
  task automatic run(input logic [31:0] a_src, input logic [31:0] a_dst, input logic [15:0] a_len,
                     input int poke, output int cyc, output int gap);
    int k;
    logic stl, pw;
    logic [31:0] pa;
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    src = a_src; dst = a_dst; len = a_len; start = 1'b1;
    tick();
    start = 1'b0; src = 32'hBAD0_0000; dst = 32'hBAD0_1000; len = 16'h7; dst_fixed = 1'b0;
    k = 1; cyc = -1; gap = 0;
    while (cyc < 0 && k < 200) begin
      if (done) begin
        cyc = k;
      end else begin
        if (!busy) gap++;
        stl = (htrans == 2'b10) && !hready;
        pa = haddr;
        pw = hwrite;
        if (k == poke) begin
          start = 1'b1;
          len = 16'h0;
        end
        tick();
        start = 1'b0;
        k++;
        if (stl) begin
          chk("addr_hold", haddr, pa);
          chk("trans_hold", htrans, 2'b10);
          chk("write_hold", hwrite, pw);
        end
      end
    end
  endtask

  task automatic finish_block(input string tag);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    tick();
    chk({tag, "_done_1cyc"}, done, 1'b0);
    chk({tag, "_busy_clr"}, busy, 1'b0);
  endtask

  initial begin
    int cyc, gap, seen;
    rst_n = 1'b0; start = 1'b0; src = 32'h0; dst = 32'h0; len = 16'h0; dst_fixed = 1'b0;
    s_clr = 1'b0; cfg_dwait = 0; cfg_stall_rd = 0; cfg_err_rd = 0;
    #12;
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_hwrite", hwrite, 1'b0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("hsize", hsize, 3'b010);
    chk("hburst", hburst, 3'b000);
    chk("hprot", hprot, 4'b0011);
    chk("hmastlock", hmastlock, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // len=3 zero-wait copy
    run(32'h2000_0000, 32'h2000_0100, 16'd3, -1, cyc, gap);
    chk("t2_cycles", cyc, 13);
    chk("t2_busy_gap", gap, 0);
    chk("t2_nr", s_nr, 3);
    chk("t2_nw", s_nw, 3);
    chk("t2_rd0", rlog[0], 32'h2000_0000);
    chk("t2_rd2", rlog[2], 32'h2000_0008);
    chk("t2_wa0", wlog_a[0], 32'h2000_0100);
    chk("t2_wa1", wlog_a[1], 32'h2000_0104);
    chk("t2_wa2", wlog_a[2], 32'h2000_0108);
    chk("t2_wd0", wlog_d[0], 32'h7A5A_0F0F);
    chk("t2_wd1", wlog_d[1], 32'h7A5A_0F0B);
    chk("t2_wd2", wlog_d[2], 32'h7A5A_0F07);
    chk("t2_err", err, 1'b0);
    finish_block("t2");

    // same copy with 2 data-phase waits and one stalled read address phase
    cfg_dwait = 2; cfg_stall_rd = 2;
    run(32'h2000_0000, 32'h2000_0100, 16'd3, -1, cyc, gap);
    chk("t3_cycles", cyc, 26);
    chk("t3_rd1", rlog[1], 32'h2000_0004);
    chk("t3_wa2", wlog_a[2], 32'h2000_0108);
    chk("t3_wd0", wlog_d[0], 32'h7A5A_0F0F);
    chk("t3_wd1", wlog_d[1], 32'h7A5A_0F0B);
    chk("t3_wd2", wlog_d[2], 32'h7A5A_0F07);
    chk("t3_err", err, 1'b0);
    finish_block("t3");
    cfg_dwait = 0; cfg_stall_rd = 0;

    // error on the second read
    cfg_err_rd = 2;
    run(32'h2000_0000, 32'h2000_0100, 16'd4, -1, cyc, gap);
    chk("t4_cycles", cyc, 7);
    chk("t4_err", err, 1'b1);
    chk("t4_nr", s_nr, 2);
    chk("t4_nw", s_nw, 1);
    chk("t4_wa0", wlog_a[0], 32'h2000_0100);
    chk("t4_wd0", wlog_d[0], 32'h7A5A_0F0F);
    finish_block("t4");
    for (int i = 0; i < 6; i++) tick();
    chk("t4_no_more_rd", s_nr, 2);
    chk("t4_no_more_wr", s_nw, 1);
    chk("t4_err_sticky", err, 1'b1);
    cfg_err_rd = 0;

    // len=0: immediate done, no bus traffic, err cleared by the start
    run(32'h2000_0000, 32'h2000_0100, 16'd0, -1, cyc, gap);
    chk("t5_len0_cycles", cyc, 1);
    chk("t5_len0_err_clr", err, 1'b0);
    chk("t5_len0_nr", s_nr, 0);
    chk("t5_len0_nw", s_nw, 0);
    finish_block("t5a");

    // address wrap plus a start pulse while busy
    run(32'hFFFF_FFFC, 32'h3000_0000, 16'd2, 3, cyc, gap);
    chk("t5_wrap_cycles", cyc, 9);
    chk("t5_wrap_rd0", rlog[0], 32'hFFFF_FFFC);
    chk("t5_wrap_rd1", rlog[1], 32'h0000_0000);
    chk("t5_wrap_wa1", wlog_a[1], 32'h3000_0004);
    chk("t5_wrap_wd0", wlog_d[0], 32'hA5A5_F0F3);
    chk("t5_wrap_wd1", wlog_d[1], 32'h5A5A_0F0F);
    chk("t5_wrap_nw", s_nw, 2);
    finish_block("t5b");
    tick();
    chk("t5_idle_after", busy, 1'b0);

    // reset during a write address phase
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    src = 32'h1000_0000; dst = 32'h1000_0100; len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    while (!(htrans == 2'b10 && hwrite) && seen < 20) begin
      tick();
      seen++;
    end
    chk("t1_reached_wr_addr", hwrite, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_htrans", htrans, 2'b00);
    chk("t1_hwrite", hwrite, 1'b0);
    chk("t1_haddr", haddr, 32'h0);
    chk("t1_hwdata", hwdata, 32'h0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done, 1'b0);
    chk("t1_err", err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (done || htrans != 2'b00) seen++;
      tick();
    end
    chk("t1_quiet_after_rst", seen, 0);

`ifdef AHB_DMA_DST_FIXED_EN
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    src = 32'h2000_0000; dst = 32'h4000_0010; len = 16'd3; dst_fixed = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; dst_fixed = 1'b0; len = 16'h7;
    cyc = -1;
    for (int k = 1; k < 100 && cyc < 0; k++) begin
      if (done) cyc = k;
      else tick();
    end
    chk("t6_cycles", cyc, 13);
    chk("t6_wa0", wlog_a[0], 32'h4000_0010);
    chk("t6_wa1", wlog_a[1], 32'h4000_0010);
    chk("t6_wa2", wlog_a[2], 32'h4000_0010);
    chk("t6_wd2", wlog_d[2], 32'h7A5A_0F07);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
